// File: rtl/isa_pkg.sv
// Shared definitions for the 20-bit ISA: field widths, opcode map and fetch states.
package isa_pkg;

  localparam int unsigned IW  = 20;
  localparam int unsigned AW  = 9;
  localparam int unsigned OPW = 5;

  typedef enum logic [OPW-1:0] {
    OpAdd  = 5'd0,
    OpSub  = 5'd1,
    OpXor  = 5'd2,
    OpAnd  = 5'd3,
    OpSll  = 5'd4,
    OpSrl  = 5'd5,
    OpCmp  = 5'd6,
    OpBe   = 5'd7,
    OpBl   = 5'd8,
    OpBg   = 5'd9,
    OpBa   = 5'd10,
    OpMov  = 5'd11,
    OpLd   = 5'd12,
    OpSt   = 5'd13,
    OpDone = 5'd14
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/instr_ram.sv
// Instruction store: one synchronous write port, one registered read port with enable.
// A read of the address being written on the same edge returns the new word.
module instr_ram #(
  parameter int unsigned IW    = 20,
  parameter int unsigned AW    = 9,
  parameter int unsigned DEPTH = 2 ** AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);

  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_rdata;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds while disabled; cleared by reset so the fetched word reads zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer over a writable instruction store: load port, start, stall,
// PC-relative branch redirect with a one-cycle squash, and halt on the DONE opcode.
module instr_fetch_unit #(
  parameter int unsigned     IW      = isa_pkg::IW,
  parameter int unsigned     AW      = isa_pkg::AW,
  parameter int unsigned     OPW     = isa_pkg::OPW,
  parameter logic [OPW-1:0]  DONE_OP = isa_pkg::OpDone
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          stall,
  input  logic          br_take,
  input  logic [AW-1:0] br_off,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  output logic          done,
  output logic          busy,
  output logic          ld_err
);

  import isa_pkg::*;

  fetch_state_e  r_state, w_state_next;
  logic [AW-1:0] r_pc, w_pc_next;        // address of the next word to read
  logic [AW-1:0] r_inst_pc, w_inst_pc_next;
  logic          r_valid, w_valid_next;
  logic          r_ld_err, w_ld_err_next;

  logic          w_not_fetch, w_start_acc, w_we, w_re, w_adv;
  logic          w_retire, w_squash;
  logic [AW-1:0] w_raddr, w_target;
  logic [IW-1:0] w_rdata;

  assign w_not_fetch = (r_state != StFetch);
  assign w_start_acc = start & w_not_fetch;
  assign w_we        = ld_en & w_not_fetch;
  assign w_adv       = (r_state == StFetch) & ~stall;
  // DONE beats a branch on the same word.
  assign w_retire    = w_adv & r_valid & (w_rdata[IW-1 -: OPW] == DONE_OP);
  assign w_squash    = w_adv & r_valid & br_take & ~w_retire;
  assign w_target    = r_inst_pc + br_off;
  assign w_raddr     = w_start_acc ? start_addr : r_pc;
  assign w_re        = w_start_acc | (w_adv & ~w_squash & ~w_retire);

  instr_ram #(
    .IW (IW),
    .AW (AW)
  ) u_ram (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_we    (w_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Next-state: start, sequential advance, branch squash, DONE retire, load error.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_inst_pc_next = r_inst_pc;
    w_valid_next   = r_valid;
    w_ld_err_next  = r_ld_err;
    unique case (r_state)
      StIdle, StHalt: begin
        if (start) begin
          w_state_next   = StFetch;
          w_pc_next      = start_addr + AW'(1);
          w_inst_pc_next = start_addr;
          w_valid_next   = 1'b1;
          w_ld_err_next  = 1'b0;
        end
      end
      StFetch: begin
        if (ld_en) begin
          w_ld_err_next = 1'b1;
        end
        if (w_retire) begin
          w_state_next = StHalt;
          w_valid_next = 1'b0;
        end else if (w_squash) begin
          w_pc_next    = w_target;
          w_valid_next = 1'b0;
        end else if (w_adv) begin
          w_pc_next      = r_pc + AW'(1);
          w_inst_pc_next = r_pc;
          w_valid_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_inst_pc <= w_inst_pc_next;
      r_valid   <= w_valid_next;
      r_ld_err  <= w_ld_err_next;
    end
  end

  assign inst       = w_rdata;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;
  assign done       = w_retire;
  assign busy       = (r_state == StFetch);
  assign ld_err     = r_ld_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized programs, all checked
// against a behavioural model built on a plain memory array.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        ld_en, start, stall, br_take;
  logic [8:0]  ld_addr, start_addr, br_off;
  logic [19:0] ld_data;
  logic [19:0] inst;
  logic [8:0]  inst_pc;
  logic        inst_valid, done, busy, ld_err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 idle, 1 fetching, 2 halted.
  logic [19:0] m_mem [512];
  int          m_state;
  logic        m_valid;
  logic [19:0] m_inst;
  logic [8:0]  m_pc;
  logic [8:0]  m_next;
  logic        m_err;

  instr_fetch_unit dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .br_take    (br_take),
    .br_off     (br_off),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .done       (done),
    .busy       (busy),
    .ld_err     (ld_err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] rand_word();
    logic [31:0] r;
    logic [4:0]  op;
    r  = $urandom();
    op = ($urandom_range(0, 7) == 0) ? 5'd14 : 5'($urandom_range(0, 13));
    return {op, r[14:0]};
  endfunction

  task automatic idle_inputs();
    ld_en = 0; start = 0; stall = 0; br_take = 0;
    ld_addr = '0; start_addr = '0; br_off = '0; ld_data = '0;
  endtask

  task automatic model_reset();
    m_state = 0; m_valid = 0; m_inst = '0; m_pc = '0; m_next = '0; m_err = 0;
  endtask

  task automatic model_update();
    if (m_state != 1) begin
      if (ld_en) m_mem[ld_addr] = ld_data;
      if (start) begin
        m_state = 1; m_err = 0; m_valid = 1;
        m_pc = start_addr; m_inst = m_mem[start_addr]; m_next = start_addr + 9'd1;
      end
    end else begin
      if (ld_en) m_err = 1;
      if (!stall) begin
        if (m_valid && m_inst[19:15] == 5'd14) begin
          m_state = 2; m_valid = 0;
        end else if (m_valid && br_take) begin
          m_valid = 0; m_next = m_pc + br_off;
        end else begin
          m_valid = 1; m_pc = m_next; m_inst = m_mem[m_next]; m_next = m_next + 9'd1;
        end
      end
    end
  endtask

  // Compare all outputs mid-cycle, then advance one clock and the model with it.
  task automatic tick();
    logic exp_done;
    @(negedge Clk);
    exp_done = (m_state == 1) && m_valid && (m_inst[19:15] == 5'd14) && !stall;
    check("busy", 32'(busy), 32'(m_state == 1));
    check("inst_valid", 32'(inst_valid), 32'(m_valid));
    check("done", 32'(done), 32'(exp_done));
    check("ld_err", 32'(ld_err), 32'(m_err));
    if (m_valid) begin
      check("inst", 32'(inst), 32'(m_inst));
      check("inst_pc", 32'(inst_pc), 32'(m_pc));
    end
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic load(input logic [8:0] a, input logic [19:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic start_at(input logic [8:0] a);
    start = 1; start_addr = a;
    tick();
    start = 0; ld_en = 0;
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget && m_state == 1; i++) tick();
    check("halt_reached", 32'(busy), 32'(0));
  endtask

  // Assert reset between edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset();
    #2;
    Reset_n = 0;
    idle_inputs();
    #1;
    check("rst_inst", 32'(inst), 32'(0));
    check("rst_inst_pc", 32'(inst_pc), 32'(0));
    check("rst_valid", 32'(inst_valid), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ld_err", 32'(ld_err), 32'(0));
    model_reset();
    @(negedge Clk);
    Reset_n = 1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [8:0]  sa;
    logic [19:0] wd;
    idle_inputs();
    model_reset();
    Reset_n = 0;
    #12;
    check("init_valid", 32'(inst_valid), 32'(0));
    check("init_busy", 32'(busy), 32'(0));
    check("init_inst_pc", 32'(inst_pc), 32'(0));
    check("init_ld_err", 32'(ld_err), 32'(0));
    @(negedge Clk);
    Reset_n = 1;
    @(posedge Clk);
    #1;

    for (int a = 0; a < 512; a++) load(9'(a), rand_word());

    // Basic program
    load(9'd0, 20'h01623);
    load(9'd1, 20'h0C300);
    load(9'd2, 20'h70000);
    start_at(9'd0);
    check("t1_inst0", 32'(inst), 32'h01623);
    check("t1_valid0", 32'(inst_valid), 32'(1));
    tick();
    check("t1_inst1", 32'(inst), 32'h0C300);
    tick();
    check("t1_inst2", 32'(inst), 32'h70000);
    check("t1_done", 32'(done), 32'(1));
    tick();
    check("t1_busy_off", 32'(busy), 32'(0));
    check("t1_valid_off", 32'(inst_valid), 32'(0));

    // Backward branch with one bubble
    load(9'd3, 20'h70000);
    load(9'h010, 20'h08010);
    start_at(9'h010);
    check("t2_pc10", 32'(inst_pc), 32'h010);
    br_take = 1; br_off = 9'h1F3;
    tick();
    br_take = 0;
    check("t2_bubble", 32'(inst_valid), 32'(0));
    tick();
    check("t2_valid", 32'(inst_valid), 32'(1));
    check("t2_target", 32'(inst_pc), 32'h003);
    run_to_halt(10);

    // Stall freeze
    load(9'd5, 20'h08005);
    load(9'd6, 20'h08006);
    load(9'd7, 20'h70000);
    start_at(9'd5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_frozen_pc", 32'(inst_pc), 32'd5);
      check("t3_frozen_inst", 32'(inst), 32'h08005);
    end
    stall = 0;
    tick();
    check("t3_pc6", 32'(inst_pc), 32'd6);
    tick();
    check("t3_pc7", 32'(inst_pc), 32'd7);
    run_to_halt(10);

    // Address wrap
    load(9'h1FF, 20'h00001);
    start_at(9'h1FF);
    check("t4_pc1ff", 32'(inst_pc), 32'h1FF);
    tick();
    check("t4_pc000", 32'(inst_pc), 32'h000);
    tick();
    check("t4_pc001", 32'(inst_pc), 32'h001);
    run_to_halt(10);

    // Load while fetching is refused
    start_at(9'd0);
    ld_en = 1; ld_addr = 9'd1; ld_data = 20'h12345;
    tick();
    ld_en = 0;
    check("t5_ld_err", 32'(ld_err), 32'(1));
    run_to_halt(10);
    check("t5_ld_err_halt", 32'(ld_err), 32'(1));
    start_at(9'd1);
    check("t5_old_word", 32'(inst), 32'h0C300);
    check("t5_err_clear", 32'(ld_err), 32'(0));
    run_to_halt(10);

    // Asynchronous reset mid-fetch, then replay
    start_at(9'd0);
    tick();
    async_reset();
    start_at(9'd0);
    check("t6_inst0", 32'(inst), 32'h01623);
    tick();
    check("t6_inst1", 32'(inst), 32'h0C300);
    tick();
    check("t6_done", 32'(done), 32'(1));
    tick();
    check("t6_busy_off", 32'(busy), 32'(0));

    // Randomized programs
    for (int ep = 0; ep < 40; ep++) begin
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
        load(9'($urandom_range(0, 511)), rand_word());
      end
      sa = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) begin
        wd = rand_word();
        ld_en = 1; ld_addr = sa; ld_data = wd;
        start_at(sa);
        check("wr_first", 32'(inst), 32'(wd));
      end else begin
        start_at(sa);
      end
      for (int c = 0; c < 200 && m_state == 1; c++) begin
        stall      = ($urandom_range(0, 3) == 0);
        br_take    = ($urandom_range(0, 7) == 0);
        br_off     = 9'($urandom_range(0, 511));
        ld_en      = ($urandom_range(0, 19) == 0);
        ld_addr    = 9'($urandom_range(0, 511));
        ld_data    = rand_word();
        start      = ($urandom_range(0, 9) == 0);
        start_addr = 9'($urandom_range(0, 511));
        tick();
      end
      idle_inputs();
      if (m_state == 1) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
